// File: rtl/sram_rw_ctrl_1k256_pkg.sv
// Shared constants and types for the 1024-set x 256-bit BRAM access controller.
//   SETS/ADDR_W/DATA_W/WAYS : array geometry
//   WAY_W                   : bits covered by one way-mask bit
//   WMASK_ALL               : all-ways mask used by the zero sweep
//   state_t                 : controller state (CLEAR sweep, RUN service)
//   arr_req_t               : one cycle of array-port drive
package sram_rw_ctrl_1k256_pkg;
  localparam int SETS   = 1024;
  localparam int ADDR_W = $clog2(SETS);
  localparam int DATA_W = 256;
  localparam int WAYS   = 4;
  localparam int WAY_W  = DATA_W / WAYS;

  localparam logic [WAYS-1:0] WMASK_ALL = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic              en;
    logic              wmode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WAYS-1:0]   wmask;
  } arr_req_t;
endpackage

// File: rtl/sram_rw_ctrl_1k256_read_hold.sv
// Read-response tracker for the 1-cycle-latency array.
//   clock, reset  : clock / synchronous active-high reset
//   rd_fire       : a read was issued to the array this cycle
//   arr_rdata     : array read data (valid the cycle after rd_fire)
//   r_resp_valid  : pulse, arr_rdata is fresh this cycle
//   r_resp_data   : fresh data on the pulse, last captured data otherwise
module sram_read_hold
  import sram_rw_ctrl_1k256_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data
);
  logic              rd_pending;
  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pending <= 1'b0;
      hold_reg   <= '0;
    end else begin
      rd_pending <= rd_fire;
      if (rd_pending) hold_reg <= arr_rdata;
    end
  end

  // Bypass the capture register on the response cycle so data is usable
  // in the same cycle the pulse is seen.
  assign r_resp_valid = rd_pending;
  assign r_resp_data  = rd_pending ? arr_rdata : hold_reg;
endmodule

// File: rtl/sram_rw_ctrl_1k256.sv
// Access controller in front of the 1024x256 single-port BRAM wrapper.
// Zero-sweeps the array after reset, then arbitrates a write channel and a
// read channel onto the one RW port (write wins) and tracks read latency.
//   clock, reset            : clock / synchronous active-high reset
//   w_valid/w_ready/w_*     : write request channel (set, data, way mask)
//   r_valid/r_ready/r_set   : read request channel
//   r_resp_valid/r_resp_data: read response pulse, data held afterwards
//   reset_done              : sweep complete, controller in RUN
//   arr_*                   : array port drive (combinational) and read data
module sram_rw_ctrl_1k256
  import sram_rw_ctrl_1k256_pkg::*;
#(
  parameter bit SHOULD_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_set,
  input  logic [DATA_W-1:0] w_data,
  input  logic [WAYS-1:0]   w_waymask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_set,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              reset_done,
  output logic              arr_en,
  output logic              arr_wmode,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_wdata,
  output logic [WAYS-1:0]   arr_wmask,
  input  logic [DATA_W-1:0] arr_rdata
);
  localparam state_t RST_STATE = SHOULD_RESET ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  arr_req_t          req;
  logic              rd_fire;

  // Sweep FSM. The counter stops on the last set rather than wrapping, so
  // the sweep covers every set exactly once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RST_STATE;
      sweep_cnt <= '0;
    end else if (state == CLEAR) begin
      if (sweep_cnt == LAST_SET) state <= RUN;
      else                       sweep_cnt <= sweep_cnt + ADDR_W'(1);
    end
  end

  assign reset_done = (state == RUN);
  assign w_ready    = (state == RUN);
  assign r_ready    = (state == RUN) && !w_valid;

  // Port arbitration. A zero-mask write still takes the port, which is
  // what blocks a concurrent read.
  always_comb begin
    req     = '0;
    rd_fire = 1'b0;
    if (state == CLEAR) begin
      req.en    = 1'b1;
      req.wmode = 1'b1;
      req.addr  = sweep_cnt;
      req.wmask = WMASK_ALL;
    end else if (w_valid) begin
      req.en    = 1'b1;
      req.wmode = 1'b1;
      req.addr  = w_set;
      req.wdata = w_data;
      req.wmask = w_waymask;
    end else if (r_valid) begin
      req.en   = 1'b1;
      req.addr = r_set;
      rd_fire  = 1'b1;
    end
  end

  assign arr_en    = req.en;
  assign arr_wmode = req.wmode;
  assign arr_addr  = req.addr;
  assign arr_wdata = req.wdata;
  assign arr_wmask = req.wmask;

  sram_read_hold u_read_hold (
    .clock        (clock),
    .reset        (reset),
    .rd_fire      (rd_fire),
    .arr_rdata    (arr_rdata),
    .r_resp_valid (r_resp_valid),
    .r_resp_data  (r_resp_data)
  );
endmodule

// File: tb/tb_sram_rw_ctrl_1k256.sv
// Self-checking bench: behavioural array behind the DUT, plus a reference
// memory image and expected response kept at transaction level.
module tb_sram_rw_ctrl_1k256;
  import sram_rw_ctrl_1k256_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              w_valid, w_ready;
  logic [ADDR_W-1:0] w_set;
  logic [DATA_W-1:0] w_data;
  logic [WAYS-1:0]   w_waymask;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_set;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              reset_done;
  logic              arr_en, arr_wmode;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [WAYS-1:0]   arr_wmask;
  logic [DATA_W-1:0] arr_rdata;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] ref_mem [SETS];
  logic [DATA_W-1:0] exp_hold;

  always #5 clock = ~clock;

  sram_rw_ctrl_1k256 dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_set(w_set), .w_data(w_data),
    .w_waymask(w_waymask),
    .r_valid(r_valid), .r_ready(r_ready), .r_set(r_set),
    .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
    .reset_done(reset_done),
    .arr_en(arr_en), .arr_wmode(arr_wmode), .arr_addr(arr_addr),
    .arr_wdata(arr_wdata), .arr_wmask(arr_wmask), .arr_rdata(arr_rdata)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] data,
                                              input logic [WAYS-1:0] mask);
    logic [DATA_W-1:0] r;
    r = old;
    for (int w = 0; w < WAYS; w++)
      if (mask[w]) r[w*WAY_W +: WAY_W] = data[w*WAY_W +: WAY_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Array model: 1-cycle read latency, garbage contents at power-up.
  logic [DATA_W-1:0] arr_mem [SETS];
  logic arr_init = 1'b0;
  always @(posedge clock) begin
    if (!arr_init) begin
      for (int i = 0; i < SETS; i++) arr_mem[i] <= rand_data();
      arr_init <= 1'b1;
    end else if (arr_en) begin
      if (arr_wmode) arr_mem[arr_addr] <= merge(arr_mem[arr_addr], arr_wdata, arr_wmask);
      else           arr_rdata <= arr_mem[arr_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    w_valid = 1'b0; r_valid = 1'b0;
    w_set = '0; r_set = '0; w_data = '0; w_waymask = '0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < SETS; i++) ref_mem[i] = '0;
    exp_hold = '0;
  endtask

  task automatic do_write(input int set, input logic [DATA_W-1:0] data,
                          input logic [WAYS-1:0] mask);
    w_valid = 1'b1; w_set = ADDR_W'(set); w_data = data; w_waymask = mask;
    r_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({arr_en, arr_wmode, arr_addr, arr_wdata, arr_wmask, w_ready} !==
        {1'b1, 1'b1, ADDR_W'(set), data, mask, 1'b1}) begin
      errors++;
      $display("FAIL write_port set=%0d: en=%b wmode=%b addr=%0d mask=%h rdy=%b, need en=1 wmode=1 addr=%0d mask=%h rdy=1",
               set, arr_en, arr_wmode, arr_addr, arr_wmask, w_ready, set, mask);
    end
    ref_mem[set] = merge(ref_mem[set], data, mask);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic do_read(input int set);
    logic [DATA_W-1:0] exp;
    w_valid = 1'b0; r_valid = 1'b1; r_set = ADDR_W'(set);
    @(negedge clock);
    checks++;
    if ({r_ready, arr_en, arr_wmode, arr_addr} !== {1'b1, 1'b1, 1'b0, ADDR_W'(set)}) begin
      errors++;
      $display("FAIL read_port set=%0d: rdy=%b en=%b wmode=%b addr=%0d, need 1 1 0 %0d",
               set, r_ready, arr_en, arr_wmode, arr_addr, set);
    end
    exp = ref_mem[set];
    tick();
    r_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== exp) begin
      errors++;
      $display("FAIL read_resp set=%0d: valid=%b data=%h, need valid=1 data=%h",
               set, r_resp_valid, r_resp_data, exp);
    end
    exp_hold = exp;
    tick();
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (reset_done !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    checks++;
    if (reset_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timeout: reset_done=%b after %0d cycles, need 1", reset_done, n);
    end
    clear_ref();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    w_valid = 1'b1; w_set = 10'd3; w_data = rand_data(); w_waymask = 4'hF;
    r_valid = 1'b1; r_set = 10'd4;
    repeat (3) tick();
    @(negedge clock);
    checks++;
    if ({reset_done, r_resp_valid, r_resp_data, w_ready, r_ready} !== {4'b0000, {DATA_W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: done=%b rv=%b rdata=%h wr=%b rr=%b, need all 0",
               reset_done, r_resp_valid, r_resp_data, w_ready, r_ready);
    end
    tick();
  endtask

  task automatic test_clear_sweep();
    logic [ADDR_W-1:0] a;
    reset = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      w_valid = 1'($urandom); r_valid = 1'($urandom);
      w_set = ADDR_W'($urandom); r_set = ADDR_W'($urandom);
      w_data = rand_data(); w_waymask = 4'($urandom);
      a = ADDR_W'(i);
      @(negedge clock);
      checks++;
      if ({arr_en, arr_wmode, arr_addr, arr_wdata, arr_wmask, w_ready, r_ready, reset_done} !==
          {1'b1, 1'b1, a, {DATA_W{1'b0}}, 4'hF, 3'b000}) begin
        errors++;
        $display("FAIL sweep_cycle %0d: en=%b wm=%b addr=%0d wdata_nz=%b mask=%h wr=%b rr=%b done=%b",
                 i, arr_en, arr_wmode, arr_addr, |arr_wdata, arr_wmask, w_ready, r_ready, reset_done);
      end
      tick();
    end
    idle();
    @(negedge clock);
    checks++;
    if (reset_done !== 1'b1 || arr_en !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: done=%b en=%b, need done=1 en=0", reset_done, arr_en);
    end
    clear_ref();
    tick();
    do_read(0);
    do_read(SETS-1);
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] a5;
    int s;
    a5 = {(DATA_W/8){8'hA5}};
    do_write(10, a5, 4'hF);
    do_read(10);
    checks++;
    if (exp_hold !== a5) begin
      errors++;
      $display("FAIL wr_rd_model: model=%h need %h", exp_hold, a5);
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 1) begin
        s = $urandom_range(0, SETS-1);
        w_valid = 1'b1; w_set = ADDR_W'(s); w_data = rand_data(); w_waymask = 4'($urandom);
        ref_mem[s] = merge(ref_mem[s], w_data, w_waymask);
      end else idle();
      @(negedge clock);
      checks++;
      if (r_resp_valid !== 1'b0 || r_resp_data !== a5) begin
        errors++;
        $display("FAIL hold_cycle %0d: valid=%b data=%h, need valid=0 data=%h", i, r_resp_valid, r_resp_data, a5);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_partial_mask();
    do_write(5, '1, 4'hF);
    do_write(5, '0, 4'b0101);
    do_read(5);
    @(negedge clock);
    checks++;
    if (r_resp_data !== {{WAY_W{1'b1}}, {WAY_W{1'b0}}, {WAY_W{1'b1}}, {WAY_W{1'b0}}}) begin
      errors++;
      $display("FAIL partial_mask: data=%h, need ways 1,3 ones and ways 0,2 zero", r_resp_data);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [DATA_W-1:0] d;
    d = rand_data();
    w_valid = 1'b1; w_set = 10'd20; w_data = d; w_waymask = 4'hF;
    r_valid = 1'b1; r_set = 10'd20;
    @(negedge clock);
    checks++;
    if ({r_ready, w_ready, arr_en, arr_wmode, arr_addr} !== {1'b0, 1'b1, 1'b1, 1'b1, 10'd20}) begin
      errors++;
      $display("FAIL conflict_arb: rr=%b wr=%b en=%b wm=%b addr=%0d, need 0 1 1 1 20",
               r_ready, w_ready, arr_en, arr_wmode, arr_addr);
    end
    ref_mem[20] = merge(ref_mem[20], d, 4'hF);
    tick();
    w_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({r_resp_valid, r_ready, arr_en, arr_wmode} !== 4'b0110) begin
      errors++;
      $display("FAIL conflict_retry: rv=%b rr=%b en=%b wm=%b, need 0 1 1 0",
               r_resp_valid, r_ready, arr_en, arr_wmode);
    end
    tick();
    r_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (r_resp_valid !== 1'b1 || r_resp_data !== d) begin
      errors++;
      $display("FAIL conflict_resp: valid=%b data=%h, need 1 %h", r_resp_valid, r_resp_data, d);
    end
    exp_hold = d;
    tick();
  endtask

  task automatic test_zero_mask();
    do_write(7, rand_data() | 256'h1, 4'hF);
    w_valid = 1'b1; w_set = 10'd7; w_data = rand_data(); w_waymask = 4'h0;
    r_valid = 1'b1; r_set = 10'd7;
    @(negedge clock);
    checks++;
    if ({r_ready, arr_en, arr_wmode, arr_wmask} !== {1'b0, 1'b1, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL zero_mask_port: rr=%b en=%b wm=%b mask=%h, need 0 1 1 0",
               r_ready, arr_en, arr_wmode, arr_wmask);
    end
    tick();
    do_read(7);
  endtask

  // Back-to-back reads first, then a random write/read mix on a few sets
  // so read-after-write hazards occur often.
  task automatic test_back_to_back();
    logic              exp_v;
    logic [DATA_W-1:0] exp_d;
    int                s;
    exp_v = 1'b0; exp_d = exp_hold;
    for (int i = 0; i < 300; i++) begin
      w_valid = (i < 60) ? 1'b0 : ($urandom_range(0, 2) == 0);
      r_valid = (i < 60) ? 1'b1 : 1'($urandom);
      w_set = ADDR_W'($urandom_range(0, 15)); r_set = ADDR_W'($urandom_range(0, 15));
      w_data = rand_data(); w_waymask = 4'($urandom);
      @(negedge clock);
      checks++;
      if (r_resp_valid !== exp_v || r_resp_data !== exp_d || r_ready !== !w_valid) begin
        errors++;
        $display("FAIL random_cycle %0d: rv=%b rr=%b data=%h, need rv=%b rr=%b data=%h",
                 i, r_resp_valid, r_ready, r_resp_data, exp_v, !w_valid, exp_d);
      end
      if (w_valid) begin
        s = int'(w_set);
        ref_mem[s] = merge(ref_mem[s], w_data, w_waymask);
        exp_v = 1'b0;
      end else if (r_valid) begin
        exp_v = 1'b1;
        exp_d = ref_mem[int'(r_set)];
      end else exp_v = 1'b0;
      tick();
    end
    idle();
    @(negedge clock);
    checks++;
    if (r_resp_valid !== exp_v || r_resp_data !== exp_d) begin
      errors++;
      $display("FAIL random_tail: rv=%b data=%h, need %b %h", r_resp_valid, r_resp_data, exp_v, exp_d);
    end
    exp_hold = exp_d;
    tick();
  endtask

  task automatic test_midop_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (500) tick();
    @(negedge clock);
    checks++;
    if (arr_addr !== 10'd500 || arr_wmode !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_pos: addr=%0d wm=%b, need 500 1", arr_addr, arr_wmode);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({arr_en, arr_wmode, arr_addr, reset_done} !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL midsweep_restart: en=%b wm=%b addr=%0d done=%b, need 1 1 0 0",
               arr_en, arr_wmode, arr_addr, reset_done);
    end
    tick();
    wait_sweep();
    do_write(3, rand_data() | 256'h1, 4'hF);
    do_read(3);
    r_valid = 1'b1; r_set = 10'd3;
    tick();
    r_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({r_resp_valid, r_resp_data, arr_addr, reset_done} !== {1'b0, {DATA_W{1'b0}}, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL run_reset: rv=%b data=%h addr=%0d done=%b, need 0 0 0 0",
               r_resp_valid, r_resp_data, arr_addr, reset_done);
    end
    tick();
    wait_sweep();
    do_read(3);
  endtask

  initial begin
    idle();
    clear_ref();
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_partial_mask();
    test_conflict();
    test_zero_mask();
    test_back_to_back();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
